// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter
//   Shares a single pixel-write master between NUM_REQ drawing engines
//   (line drawer, rectangle fill, screen clear). Arbitration is round-robin
//   with a burst limit: the current owner may keep the port for up to
//   BURST_LIMIT consecutive pixels while others wait. One pixel is forwarded
//   at a time, and the downstream completion pulse is routed back to the
//   owner as a one-cycle req_finish pulse.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   req_draw   : [NUM_REQ]     bit i set when requester i has a pixel pending
//   req_addr   : [NUM_REQ*32]  requester i address at [32i+31:32i]
//   req_color  : [NUM_REQ*16]  requester i color at [16i+15:16i]
//   req_finish : [NUM_REQ]     one-cycle pulse to the owner when its pixel is written
//   draw_out   : request to the downstream master
//   addr_out   : latched pixel address
//   color_out  : latched pixel color
//   finish_in  : downstream write-complete pulse
//   busy       : high while a pixel is being issued or retired
//   grant_id   : index of the current / most recent grantee
module pixel_write_arbiter #(
  parameter  int NUM_REQ     = 3,
  parameter  int BURST_LIMIT = 16,
  localparam int GW          = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_draw,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0] req_color,
  output logic [NUM_REQ-1:0]    req_finish,
  output logic                  draw_out,
  output logic [31:0]           addr_out,
  output logic [15:0]           color_out,
  input  logic                  finish_in,
  output logic                  busy,
  output logic [GW-1:0]         grant_id
);

  // burst_cnt only ever needs to reach BURST_LIMIT-1
  localparam int CW = (BURST_LIMIT > 1) ? $clog2(BURST_LIMIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RETIRE
  } state_t;

  state_t        state;
  logic [CW-1:0] burst_cnt;

  logic          keep_grant;
  logic          scan_found;
  logic [GW-1:0] scan_idx;
  logic [GW-1:0] winner;
  logic [CW-1:0] next_burst;

  // Winner selection for the next IDLE decision. The current owner keeps the
  // port while it is still requesting and has burst budget left; otherwise
  // the requesters are scanned starting just after the owner, wrapping
  // modulo NUM_REQ so that the owner itself is the last one considered.
  // When the scan lands back on the owner the burst count still restarts,
  // which lets a lone requester run forever with no idle penalty.
  always_comb begin
    keep_grant = req_draw[grant_id] && (burst_cnt < CW'(BURST_LIMIT - 1));
    scan_found = 1'b0;
    scan_idx   = '0;
    winner     = grant_id;
    next_burst = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = GW'((int'(grant_id) + k) % NUM_REQ);
      if (!scan_found && req_draw[scan_idx]) begin
        scan_found = 1'b1;
        winner     = scan_idx;
      end
    end
    if (keep_grant) begin
      winner     = grant_id;
      next_burst = burst_cnt + CW'(1);
    end
  end

  // Main control FSM. All outputs are registered: draw_out and busy rise on
  // the edge leaving IDLE, the address/color are latched on that same edge
  // and held through ISSUE, and req_finish is a single-cycle pulse that is
  // only ever present while in RETIRE. finish_in outside ISSUE is ignored.
  // Reset clears everything immediately, so a pixel caught mid-ISSUE is
  // abandoned without a completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      draw_out   <= 1'b0;
      addr_out   <= '0;
      color_out  <= '0;
      req_finish <= '0;
      busy       <= 1'b0;
      grant_id   <= GW'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_finish <= '0;
          if (|req_draw) begin
            grant_id  <= winner;
            burst_cnt <= next_burst;
            addr_out  <= req_addr[int'(winner)*32 +: 32];
            color_out <= req_color[int'(winner)*16 +: 16];
            draw_out  <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (finish_in) begin
            draw_out   <= 1'b0;
            req_finish <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
            state      <= RETIRE;
          end
        end
        RETIRE: begin
          req_finish <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          draw_out   <= 1'b0;
          req_finish <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb_pixel_write_arbiter
//   Self-checking bench for pixel_write_arbiter with three requesters and a
//   burst limit of 3. A transaction-level reference model tracks who owns
//   the port and how many pixels of the current burst have been used, and
//   decides each grant from the round-robin/burst rules.
module tb_pixel_write_arbiter;

  localparam int NR = 3;
  localparam int BL = 3;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req_draw;
  logic [NR*32-1:0] req_addr;
  logic [NR*16-1:0] req_color;
  logic [NR-1:0]   req_finish;
  logic            draw_out;
  logic [31:0]     addr_out;
  logic [15:0]     color_out;
  logic            finish_in;
  logic            busy;
  logic [1:0]      grant_id;

  int vectors;
  int miscompares;

  // Reference model: last owner and pixels used in its current burst
  int model_last;
  int model_used;

  int exp_order [12];
  int got_w;

  pixel_write_arbiter #(
    .NUM_REQ     (NR),
    .BURST_LIMIT (BL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_draw   (req_draw),
    .req_addr   (req_addr),
    .req_color  (req_color),
    .req_finish (req_finish),
    .draw_out   (draw_out),
    .addr_out   (addr_out),
    .color_out  (color_out),
    .finish_in  (finish_in),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Grant decision from the rules: keep the owner while it still requests
  // and has burst budget, otherwise take the first requester after it in
  // rotation order (possibly the owner again) and start a new burst.
  task automatic modelGrant(input logic [NR-1:0] rq, output int w);
    int idx;
    if (rq[model_last] && model_used < BL) begin
      w = model_last;
      model_used++;
    end else begin
      w = -1;
      for (int k = 1; k <= NR; k++) begin
        idx = (model_last + k) % NR;
        if (w < 0 && rq[idx]) w = idx;
      end
      model_used = 1;
    end
    model_last = w;
  endtask

  // Requester i presents a fresh random pixel
  task automatic present(input int i);
    req_addr[32*i +: 32]  = $urandom;
    req_color[16*i +: 16] = 16'($urandom);
    req_draw[i]           = 1'b1;
  endtask

  // Reset the DUT and the model together
  task automatic doReset();
    reset     = 1'b1;
    req_draw  = '0;
    finish_in = 1'b0;
    #1;
    checkOutput("rst_draw", 64'(draw_out), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_finish", 64'(req_finish), 64'd0);
    checkOutput("rst_grant", 64'(grant_id), 64'(NR-1));
    @(posedge clk); #1;
    reset      = 1'b0;
    model_last = NR - 1;
    model_used = 1;
  endtask

  // One complete pixel transaction, entered in IDLE just after a clock edge
  // with req_draw non-zero. draw_out must rise on the next edge, stay high
  // for exactly 'latency' cycles, then RETIRE pulses req_finish to the owner.
  // Optionally the owner's address is rewritten or its request dropped while
  // the pixel is in flight; neither may disturb the latched pixel.
  task automatic applyStimulus(input int latency, input bit do_move, input logic [31:0] move_to,
                               input bit drop_owner, output int w);
    logic [31:0] exp_addr;
    logic [15:0] exp_color;
    modelGrant(req_draw, w);
    exp_addr  = req_addr[32*w +: 32];
    exp_color = req_color[16*w +: 16];
    @(posedge clk); #1;
    checkOutput("draw_rise", 64'(draw_out), 64'd1);
    checkOutput("busy_issue", 64'(busy), 64'd1);
    checkOutput("grant", 64'(grant_id), 64'(w));
    checkOutput("addr", 64'(addr_out), 64'(exp_addr));
    checkOutput("color", 64'(color_out), 64'(exp_color));
    if (do_move) req_addr[32*w +: 32] = move_to;
    if (drop_owner) req_draw[w] = 1'b0;
    for (int c = 1; c < latency; c++) begin
      @(posedge clk); #1;
      checkOutput("draw_hold", 64'(draw_out), 64'd1);
      checkOutput("addr_hold", 64'(addr_out), 64'(exp_addr));
      checkOutput("finish_quiet", 64'(req_finish), 64'd0);
    end
    finish_in = 1'b1;
    @(posedge clk); #1;
    finish_in = 1'b0;
    checkOutput("draw_fall", 64'(draw_out), 64'd0);
    checkOutput("finish_pulse", 64'(req_finish), 64'(1 << w));
    checkOutput("busy_retire", 64'(busy), 64'd1);
    checkOutput("addr_retire", 64'(addr_out), 64'(exp_addr));
    @(posedge clk); #1;
    checkOutput("finish_clear", 64'(req_finish), 64'd0);
    checkOutput("busy_idle", 64'(busy), 64'd0);
    checkOutput("draw_idle", 64'(draw_out), 64'd0);
  endtask

  // Stimulus sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req_draw    = '0;
    req_addr    = '0;
    req_color   = '0;
    finish_in   = 1'b0;
    model_last  = NR - 1;
    model_used  = 1;
    exp_order   = '{2, 2, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0};

    doReset();
    checkOutput("rst_addr", 64'(addr_out), 64'd0);
    checkOutput("rst_color", 64'(color_out), 64'd0);

    // Idle with stray finish_in pulses: nothing may happen
    for (int c = 0; c < 10; c++) begin
      finish_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checkOutput("idle_draw", 64'(draw_out), 64'd0);
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("idle_finish", 64'(req_finish), 64'd0);
    end
    finish_in = 1'b0;

    // Single pixel from requester 1, four-cycle downstream latency
    req_draw             = 3'b010;
    req_addr[63:32]      = 32'h0000_1234;
    req_color[31:16]     = 16'hF800;
    applyStimulus(4, 1'b0, 32'h0, 1'b0, got_w);
    checkOutput("dir_grant1", 64'(grant_id), 64'd1);
    checkOutput("dir_addr1", 64'(addr_out), 64'h1234);
    checkOutput("dir_color1", 64'(color_out), 64'hF800);
    req_draw = '0;

    // All three requesting from reset: fixed rotation in bursts of three
    doReset();
    for (int i = 0; i < NR; i++) present(i);
    for (int p = 0; p < 12; p++) begin
      applyStimulus(1, 1'b0, 32'h0, 1'b0, got_w);
      checkOutput("rot_order", 64'(got_w), 64'(exp_order[p]));
      present(got_w);
    end

    // Lone requester 2: re-granted every pixel across burst wraps
    req_draw = 3'b100;
    for (int p = 0; p < 10; p++) begin
      present(2);
      applyStimulus(1 + (p % 3), 1'b0, 32'h0, 1'b0, got_w);
      checkOutput("solo_grant", 64'(grant_id), 64'd2);
    end

    // Address changed while in flight is held, then issued next time
    req_draw        = 3'b001;
    req_addr[31:0]  = 32'h100;
    applyStimulus(3, 1'b1, 32'h200, 1'b0, got_w);
    checkOutput("hold_old", 64'(addr_out), 64'h100);
    applyStimulus(2, 1'b0, 32'h0, 1'b0, got_w);
    checkOutput("hold_new", 64'(addr_out), 64'h200);

    // Randomized traffic with random latency and owner drops mid-flight
    for (int p = 0; p < 150; p++) begin
      while (req_draw == '0) begin
        @(posedge clk); #1;
        checkOutput("gap_draw", 64'(draw_out), 64'd0);
        checkOutput("gap_busy", 64'(busy), 64'd0);
        present($urandom_range(0, NR-1));
      end
      applyStimulus($urandom_range(1, 5), 1'b0, 32'h0, 1'($urandom_range(0, 3) == 0), got_w);
      for (int i = 0; i < NR; i++) begin
        if (i == got_w) begin
          if ($urandom_range(0, 9) < 7) present(i);
          else req_draw[i] = 1'b0;
        end else if (!req_draw[i] && $urandom_range(0, 9) < 4) begin
          present(i);
        end
      end
    end

    // Reset while a pixel is in flight: outputs drop without waiting for a clock
    req_draw = 3'b001;
    present(0);
    @(posedge clk); #1;
    checkOutput("pre_rst_draw", 64'(draw_out), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_draw", 64'(draw_out), 64'd0);
    checkOutput("async_busy", 64'(busy), 64'd0);
    checkOutput("async_finish", 64'(req_finish), 64'd0);
    req_draw = '0;
    @(posedge clk); #1;
    reset      = 1'b0;
    model_last = NR - 1;
    model_used = 1;

    req_draw = '0;
    present(2);
    applyStimulus(2, 1'b0, 32'h0, 1'b0, got_w);
    checkOutput("post_rst_grant2", 64'(grant_id), 64'd2);
    req_draw = '0;
    present(0);
    present(1);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, got_w);
    checkOutput("post_rst_grant0", 64'(grant_id), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
